// File: rtl/addr_gen_pkg.sv
// Shared types and defaults for the address generator.
package addr_gen_pkg;

  typedef enum logic [2:0] {
    ModeFixed  = 3'd0,
    ModeRandom = 3'd1,
    ModeWalk1  = 3'd2,
    ModeWalk0  = 3'd3,
    ModeIncr   = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } state_t;

  localparam logic [31:0] DefaultLfsrPoly = 32'h8020_0003;
  localparam logic [31:0] DefaultLfsrSeed = 32'h0000_0001;

endpackage

// File: rtl/addr_gen_unit_if.sv
// Command and address-stream bundle between the generator (master) and its user (slave).
interface addr_gen_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              start_i;
  logic [2:0]        mode_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W-1:0] addr_mask_i;
  logic [CNT_W-1:0]  trans_cnt_i;
  logic [ADDR_W-1:0] addr_o;
  logic              addr_valid_o;
  logic              addr_ready_i;
  logic              busy_o;
  logic              done_o;

  modport master (
    input  start_i, mode_i, base_addr_i, addr_mask_i, trans_cnt_i, addr_ready_i,
    output addr_o, addr_valid_o, busy_o, done_o
  );

  modport slave (
    output start_i, mode_i, base_addr_i, addr_mask_i, trans_cnt_i, addr_ready_i,
    input  addr_o, addr_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/lfsr_gen.sv
// Right-shifting Galois LFSR that steps only when adv_i is high.
module lfsr_gen #(
  parameter int unsigned  W    = 32,
  parameter logic [W-1:0] POLY = W'(32'h8020_0003),
  parameter logic [W-1:0] SEED = W'(32'h0000_0001)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         adv_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/addr_gen_unit.sv
// Address generator: issues trans_cnt addresses in one of five patterns over valid/ready.
// Define ADDR_GEN_ABORT_EN to add the abort_i input that ends a running sequence early.
module addr_gen_unit
  import addr_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [ADDR_W-1:0] LFSR_POLY = ADDR_W'(DefaultLfsrPoly),
  parameter logic [ADDR_W-1:0] LFSR_SEED = ADDR_W'(DefaultLfsrSeed)
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef ADDR_GEN_ABORT_EN
  input  logic             abort_i,
`endif
  addr_gen_unit_if.master  bus
);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d, start_mode;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer, lfsr_adv;
  logic [ADDR_W-1:0] lfsr_val, lfsr_nxt, first_addr, next_addr;

  function automatic logic [ADDR_W-1:0] win(input logic [ADDR_W-1:0] b,
                                            input logic [ADDR_W-1:0] m,
                                            input logic [ADDR_W-1:0] x);
    return (b & ~m) | (x & m);
  endfunction

  lfsr_gen #(
    .W    (ADDR_W),
    .POLY (LFSR_POLY),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .adv_i   (lfsr_adv),
    .value_o (lfsr_val)
  );

  // Value the LFSR moves to on this step; a transfer issues the window of that value.
  assign lfsr_nxt = lfsr_val[0] ? ((lfsr_val >> 1) ^ LFSR_POLY) : (lfsr_val >> 1);
  assign xfer     = valid_q & bus.addr_ready_i;

  always_comb begin
    start_mode = (bus.mode_i <= 3'd4) ? mode_t'(bus.mode_i) : ModeFixed;
    case (start_mode)
      ModeRandom: first_addr = win(bus.base_addr_i, bus.addr_mask_i, lfsr_val);
      ModeWalk1:  first_addr = {{(ADDR_W-1){1'b0}}, 1'b1};
      ModeWalk0:  first_addr = {{(ADDR_W-1){1'b1}}, 1'b0};
      default:    first_addr = bus.base_addr_i;
    endcase
    case (mode_q)
      ModeRandom: next_addr = win(base_q, mask_q, lfsr_nxt);
      ModeWalk1,
      ModeWalk0:  next_addr = {addr_q[ADDR_W-2:0], addr_q[ADDR_W-1]};
      ModeIncr:   next_addr = win(base_q, mask_q, addr_q + ADDR_W'(1));
      default:    next_addr = base_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    base_d   = base_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    lfsr_adv = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          busy_d   = 1'b1;
          lfsr_adv = 1'b1;
          if (bus.trans_cnt_i != '0) begin
            mode_d   = start_mode;
            base_d   = bus.base_addr_i;
            mask_d   = bus.addr_mask_i;
            remain_d = bus.trans_cnt_i;
            addr_d   = first_addr;
            valid_d  = 1'b1;
            state_d  = StRun;
          end else begin
            state_d = StFin;
          end
        end
      end
      StRun: begin
        if (xfer) begin
          lfsr_adv = 1'b1;
          if (remain_q == CNT_W'(1)) begin
            valid_d = 1'b0;
            state_d = StFin;
          end else begin
            remain_d = remain_q - CNT_W'(1);
            addr_d   = next_addr;
          end
        end
`ifdef ADDR_GEN_ABORT_EN
        // A same-cycle transfer above still counts; nothing further is issued.
        if (abort_i) begin
          valid_d = 1'b0;
          state_d = StFin;
        end
`endif
      end
      StFin: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      mode_q   <= ModeFixed;
      base_q   <= '0;
      mask_q   <= '0;
      addr_q   <= '0;
      remain_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      base_q   <= base_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.addr_o       = addr_q;
  assign bus.addr_valid_o = valid_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;

endmodule

// File: tb/tb_addr_gen_unit.sv
// Directed bench for addr_gen_unit at ADDR_W=8 with an 8-bit maximal LFSR.
module tb_addr_gen_unit;

  localparam int unsigned AW   = 8;
  localparam int unsigned CW   = 16;
  localparam logic [7:0]  Poly = 8'hB8;
  localparam logic [7:0]  Seed = 8'h01;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  addr_gen_unit_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

`ifdef ADDR_GEN_ABORT_EN
  logic abort_i = 1'b0;
`endif

  addr_gen_unit #(
    .ADDR_W    (AW),
    .CNT_W     (CW),
    .LFSR_POLY (Poly),
    .LFSR_SEED (Seed)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
`ifdef ADDR_GEN_ABORT_EN
    .abort_i (abort_i),
`endif
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ Poly) : (x >> 1);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_seq(input logic [2:0] mode, input logic [7:0] base, input logic [7:0] mask,
                           input logic [15:0] cnt);
    bus.mode_i      = mode;
    bus.base_addr_i = base;
    bus.addr_mask_i = mask;
    bus.trans_cnt_i = cnt;
    bus.start_i     = 1'b1;
    tick();
    bus.start_i     = 1'b0;
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0; bus.mode_i = '0; bus.base_addr_i = '0; bus.addr_mask_i = '0;
    bus.trans_cnt_i = '0; bus.addr_ready_i = 1'b0;
    rst_i = 1'b1;
    #22;
    checks++;
    if (bus.addr_o !== 8'h00 || bus.addr_valid_o !== 1'b0 || bus.busy_o !== 1'b0 ||
        bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: addr=%h valid=%b busy=%b done=%b, want all 0",
               bus.addr_o, bus.addr_valid_o, bus.busy_o, bus.done_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_incr();
    logic [7:0] exp [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
    bus.addr_ready_i = 1'b1;
    start_seq(3'd4, 8'h10, 8'h03, 16'd6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.addr_valid_o !== 1'b1 || bus.addr_o !== exp[i]) begin
        errors++;
        $display("FAIL incr[%0d]: valid=%b addr=%h, want valid=1 addr=%h",
                 i, bus.addr_valid_o, bus.addr_o, exp[i]);
      end
      tick();
    end
    checks++;
    if (bus.addr_valid_o !== 1'b0 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL incr_fin: valid=%b done=%b busy=%b, want 0 0 1",
               bus.addr_valid_o, bus.done_o, bus.busy_o);
    end
    tick();
    checks++;
    if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL incr_done: done=%b busy=%b, want 1 0", bus.done_o, bus.busy_o);
    end
    tick();
    checks++;
    if (bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL incr_done_pulse: done=%b, want 0", bus.done_o);
    end
    bus.addr_ready_i = 1'b0;
  endtask

  task automatic test_walk();
    logic [7:0] e;
    bit         seen;
    bus.addr_ready_i = 1'b1;
    start_seq(3'd2, 8'h5A, 8'hFF, 16'd9);
    e = 8'h01;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (bus.addr_valid_o !== 1'b1 || bus.addr_o !== e) begin
        errors++;
        $display("FAIL walk1[%0d]: valid=%b addr=%h, want valid=1 addr=%h",
                 i, bus.addr_valid_o, bus.addr_o, e);
      end
      e = {e[6:0], e[7]};
      tick();
    end
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      tick();
      seen = (bus.done_o === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL walk1_done: done=0 after 5 cycles, want 1");
    end
    tick();
    start_seq(3'd3, 8'h33, 8'h0F, 16'd3);
    e = 8'hFE;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.addr_valid_o !== 1'b1 || bus.addr_o !== e) begin
        errors++;
        $display("FAIL walk0[%0d]: valid=%b addr=%h, want valid=1 addr=%h",
                 i, bus.addr_valid_o, bus.addr_o, e);
      end
      e = {e[6:0], e[7]};
      tick();
    end
    tick();
    tick();
    bus.addr_ready_i = 1'b0;
  endtask

  task automatic test_fixed_toggle();
    int  xfers;
    bit  seen;
    bit  prev_busy;
    bus.addr_ready_i = 1'b1;
    start_seq(3'd0, 8'hA5, 8'h0F, 16'd3);
    xfers = 0;
    seen = 1'b0;
    prev_busy = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      bus.addr_ready_i = (c % 2 == 0);
      #1;
      if (bus.addr_valid_o === 1'b1) begin
        checks++;
        if (bus.addr_o !== 8'hA5) begin
          errors++;
          $display("FAIL fixed_addr[%0d]: addr=%h, want a5", c, bus.addr_o);
        end
        if (bus.addr_ready_i) xfers++;
      end
      prev_busy = bus.busy_o;
      tick();
      if (bus.done_o === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (bus.busy_o !== 1'b0 || prev_busy !== 1'b1) begin
          errors++;
          $display("FAIL fixed_busy_edge: busy=%b prev=%b, want 0 after 1", bus.busy_o, prev_busy);
        end
      end
    end
    checks++;
    if (!seen || xfers != 3) begin
      errors++;
      $display("FAIL fixed_count: done_seen=%b transfers=%0d, want 1 and 3", seen, xfers);
    end
    tick();
    // Undefined mode codes fall back to the fixed pattern.
    bus.addr_ready_i = 1'b0;
    start_seq(3'd7, 8'h3C, 8'hFF, 16'd1);
    checks++;
    if (bus.addr_valid_o !== 1'b1 || bus.addr_o !== 8'h3C) begin
      errors++;
      $display("FAIL mode7_fixed: valid=%b addr=%h, want 1 3c", bus.addr_valid_o, bus.addr_o);
    end
    bus.addr_ready_i = 1'b1;
    tick();
    tick();
    tick();
    bus.addr_ready_i = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] m;
    logic [7:0] e;
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    m = Seed;
    bus.addr_ready_i = 1'b1;
    start_seq(3'd1, 8'hF0, 8'h0F, 16'd16);
    e = 8'hF0 | (m & 8'h0F);
    m = lfsr_step(m);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.addr_valid_o !== 1'b1 || bus.addr_o !== e || bus.addr_o[7:4] !== 4'hF) begin
        errors++;
        $display("FAIL random[%0d]: valid=%b addr=%h, want valid=1 addr=%h",
                 i, bus.addr_valid_o, bus.addr_o, e);
      end
      tick();
      m = lfsr_step(m);
      e = 8'hF0 | (m & 8'h0F);
    end
    tick();
    checks++;
    if (bus.done_o !== 1'b1) begin
      errors++;
      $display("FAIL random_done: done=%b, want 1", bus.done_o);
    end
    tick();
    bus.addr_ready_i = 1'b0;
  endtask

  task automatic test_zero_cnt();
    start_seq(3'd4, 8'h20, 8'h0F, 16'd0);
    checks++;
    if (bus.addr_valid_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_cnt_fin: valid=%b busy=%b done=%b, want 0 1 0",
               bus.addr_valid_o, bus.busy_o, bus.done_o);
    end
    tick();
    checks++;
    if (bus.addr_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b1) begin
      errors++;
      $display("FAIL zero_cnt_done: valid=%b busy=%b done=%b, want 0 0 1",
               bus.addr_valid_o, bus.busy_o, bus.done_o);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int         xfers;
    bit         seen;
    logic [7:0] e;
    bus.addr_ready_i = 1'b0;
    start_seq(3'd4, 8'h40, 8'h0F, 16'd4);
    tick();
    start_seq(3'd2, 8'h80, 8'h00, 16'd2);
    checks++;
    if (bus.addr_valid_o !== 1'b1 || bus.addr_o !== 8'h40) begin
      errors++;
      $display("FAIL start_in_run: valid=%b addr=%h, want 1 40", bus.addr_valid_o, bus.addr_o);
    end
    bus.addr_ready_i = 1'b1;
    xfers = 0;
    seen = 1'b0;
    e = 8'h40;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (bus.addr_valid_o === 1'b1) begin
        checks++;
        if (bus.addr_o !== e) begin
          errors++;
          $display("FAIL start_ign_addr[%0d]: addr=%h, want %h", xfers, bus.addr_o, e);
        end
        xfers++;
        e = e + 8'h01;
      end
      tick();
      seen = (bus.done_o === 1'b1);
    end
    checks++;
    if (!seen || xfers != 4) begin
      errors++;
      $display("FAIL start_ign_count: done_seen=%b transfers=%0d, want 1 and 4", seen, xfers);
    end
    tick();
    bus.addr_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit bad;
    bus.addr_ready_i = 1'b1;
    start_seq(3'd2, 8'h00, 8'h00, 16'd5);
    tick();
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if (bus.addr_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b busy=%b, want 0 0", bus.addr_valid_o, bus.busy_o);
    end
    #2;
    rst_i = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.done_o !== 1'b0 || bus.addr_valid_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_mid_quiet: done or valid rose after reset, want both 0");
    end
    bus.addr_ready_i = 1'b0;
  endtask

`ifdef ADDR_GEN_ABORT_EN
  task automatic test_abort();
    bus.addr_ready_i = 1'b1;
    start_seq(3'd4, 8'h00, 8'hFF, 16'd5);
    tick();
    tick();
    checks++;
    if (bus.addr_valid_o !== 1'b1 || bus.addr_o !== 8'h02) begin
      errors++;
      $display("FAIL abort_pre: valid=%b addr=%h, want 1 02", bus.addr_valid_o, bus.addr_o);
    end
    bus.addr_ready_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if (bus.addr_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_fin: valid=%b busy=%b, want 0 1", bus.addr_valid_o, bus.busy_o);
    end
    bus.addr_ready_i = 1'b1;
    tick();
    checks++;
    if (bus.done_o !== 1'b1 || bus.addr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_done: done=%b valid=%b, want 1 0", bus.done_o, bus.addr_valid_o);
    end
    tick();
    bus.addr_ready_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_incr();
    test_walk();
    test_fixed_toggle();
    test_random();
    test_zero_cnt();
    test_start_ignored();
`ifdef ADDR_GEN_ABORT_EN
    test_abort();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
